// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter:
//   DM_AW / DM_DW   default word-address and data widths
//   PORT_PIPE/EXT   port identifiers (0 = pipeline MEM stage, 1 = loader/DMA)
//   WAIT_W          width of the port-1 starvation counter
//   dm_gnt_e        2-bit grant encoding (none, port 0, port 1)
//   byte_addr()     word address -> zero-extended 32-bit byte address
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    localparam int unsigned DM_AW  = 10;
    localparam int unsigned DM_DW  = 32;
    localparam int unsigned WAIT_W = 4;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_EXT  = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_P0   = 2'b01,
        GNT_P1   = 2'b10
    } dm_gnt_e;

    // Memory is word-addressed; byte address is the word address times four.
    function automatic logic [31:0] byte_addr(input logic [31:0] i_word_addr);
        return {i_word_addr[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// dm_arb_starve_ctr
// Saturating wait counter protecting the low-priority port from starvation.
// Counts refused cycles up to MAX_WAIT (legal 1..15) and clears on a grant.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset (counter -> 0)
//   i_inc      port 1 requested but was refused this cycle
//   i_clr      port 1 was granted this cycle (wins over i_inc)
//   o_at_max   counter has reached MAX_WAIT; port 1 must win next contest
// -----------------------------------------------------------------------------
module dm_arb_starve_ctr
    import dm_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [WAIT_W-1:0] MaxCnt = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (i_inc && (r_cnt != MaxCnt)) begin
            w_cnt_next = r_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_at_max = (r_cnt == MaxCnt);

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Arbitrates a single-port word data memory between the pipeline MEM stage
// (port 0, fixed priority) and the loader/DMA port (port 1, starvation
// protected). Grant is combinational (0-cycle), read data is registered
// (1-cycle latency). Writes produce no response.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_reqN_valid/we/addr/wdata     request from port N (N = 0, 1)
//   o_reqN_ready                   grant; transfer happens on valid && ready
//   o_rspN_valid, o_rspN_rdata     registered read response to port N
//   o_stall0                       port 0 valid but not granted
//   o_dm_addr/wdata/we             drive to data memory
//   i_dm_rdata                     combinational read data from data memory
// Optional: define DM_ARB_TRACE_EN to print every granted write in simulation.
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AW       = DM_AW,
    parameter int unsigned DW       = DM_DW,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_req0_valid,
    input  logic          i_req0_we,
    input  logic [AW-1:0] i_req0_addr,
    input  logic [DW-1:0] i_req0_wdata,
    output logic          o_req0_ready,
    output logic          o_rsp0_valid,
    output logic [DW-1:0] o_rsp0_rdata,
    output logic          o_stall0,

    input  logic          i_req1_valid,
    input  logic          i_req1_we,
    input  logic [AW-1:0] i_req1_addr,
    input  logic [DW-1:0] i_req1_wdata,
    output logic          o_req1_ready,
    output logic          o_rsp1_valid,
    output logic [DW-1:0] o_rsp1_rdata,

    output logic [AW-1:0] o_dm_addr,
    output logic [DW-1:0] o_dm_wdata,
    output logic          o_dm_we,
    input  logic [DW-1:0] i_dm_rdata
);

    dm_gnt_e       w_gnt;
    logic          w_at_max;
    logic          w_rd0;
    logic          w_rd1;

    logic          r_rsp0_valid;
    logic [DW-1:0] r_rsp0_rdata;
    logic          r_rsp1_valid;
    logic [DW-1:0] r_rsp1_rdata;

    dm_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_inc    (i_req1_valid && !o_req1_ready),
        .i_clr    (o_req1_ready),
        .o_at_max (w_at_max)
    );

    // Port 0 wins every contest unless port 1 has been refused MAX_WAIT times.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!i_reset) begin
            if (i_req0_valid && i_req1_valid) begin
                w_gnt = w_at_max ? GNT_P1 : GNT_P0;
            end else if (i_req0_valid) begin
                w_gnt = GNT_P0;
            end else if (i_req1_valid) begin
                w_gnt = GNT_P1;
            end
        end
    end

    assign o_req0_ready = (w_gnt == GNT_P0);
    assign o_req1_ready = (w_gnt == GNT_P1);
    assign o_stall0     = i_req0_valid && !o_req0_ready;

    always_comb begin
        o_dm_addr  = '0;
        o_dm_wdata = '0;
        o_dm_we    = 1'b0;
        unique case (w_gnt)
            GNT_P0: begin
                o_dm_addr  = i_req0_addr;
                o_dm_wdata = i_req0_wdata;
                o_dm_we    = i_req0_we;
            end
            GNT_P1: begin
                o_dm_addr  = i_req1_addr;
                o_dm_wdata = i_req1_wdata;
                o_dm_we    = i_req1_we;
            end
            default: begin
                o_dm_addr  = '0;
                o_dm_wdata = '0;
                o_dm_we    = 1'b0;
            end
        endcase
    end

    assign w_rd0 = o_req0_ready && !i_req0_we;
    assign w_rd1 = o_req1_ready && !i_req1_we;

    // Read data is captured only on a read grant so it holds while valid is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= w_rd0;
            r_rsp1_valid <= w_rd1;
            if (w_rd0) begin
                r_rsp0_rdata <= i_dm_rdata;
            end
            if (w_rd1) begin
                r_rsp1_rdata <= i_dm_rdata;
            end
        end
    end

    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp0_rdata = r_rsp0_rdata;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp1_rdata = r_rsp1_rdata;

`ifdef DM_ARB_TRACE_EN
    always_ff @(posedge i_clk) begin
        if (o_dm_we) begin
            $display("@%0d: *%08h <= %08h",
                     (w_gnt == GNT_P1) ? PORT_EXT : PORT_PIPE,
                     byte_addr(32'(o_dm_addr)), o_dm_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          v0, we0, v1, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rdy0, rdy1, rv0, rv1, st0;
    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          dm_we;

    logic [DW-1:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    dm_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAXW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req0_valid (v0),
        .i_req0_we    (we0),
        .i_req0_addr  (a0),
        .i_req0_wdata (d0),
        .o_req0_ready (rdy0),
        .o_rsp0_valid (rv0),
        .o_rsp0_rdata (rd0),
        .o_stall0     (st0),
        .i_req1_valid (v1),
        .i_req1_we    (we1),
        .i_req1_addr  (a1),
        .i_req1_wdata (d1),
        .o_req1_ready (rdy1),
        .o_rsp1_valid (rv1),
        .o_rsp1_rdata (rd1),
        .o_dm_addr    (dm_addr),
        .o_dm_wdata   (dm_wdata),
        .o_dm_we      (dm_we),
        .i_dm_rdata   (dm_rdata)
    );

    // Data memory: combinational read, write at the clock edge.
    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_wdata;
    end

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0001_9E37) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who should win, what the memory should see, and
    // what each port should read back, from the arbitration rules alone.
    // ------------------------------------------------------------------
    int          m_wait = 0;
    logic        m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [31:0] m_rd0 = '0, m_rd1 = '0;
    logic [31:0] shadow [0:1023];

    always @(negedge clk) begin
        int          g;  // -1: nobody, 0: port 0, 1: port 1
        logic [31:0] e_addr, e_wdata;
        logic        e_we;

        chk("rsp0_valid", 32'(rv0), 32'(m_rv0));
        chk("rsp0_rdata", rd0, m_rd0);
        chk("rsp1_valid", 32'(rv1), 32'(m_rv1));
        chk("rsp1_rdata", rd1, m_rd1);

        if (reset)               g = -1;
        else if (v0 && v1)       g = (m_wait >= int'(MAXW)) ? 1 : 0;
        else if (v0)             g = 0;
        else if (v1)             g = 1;
        else                     g = -1;

        e_addr  = (g == 0) ? 32'(a0) : (g == 1) ? 32'(a1) : 32'd0;
        e_wdata = (g == 0) ? d0      : (g == 1) ? d1      : 32'd0;
        e_we    = (g == 0) ? we0     : (g == 1) ? we1     : 1'b0;

        chk("req0_ready", 32'(rdy0), 32'(g == 0));
        chk("req1_ready", 32'(rdy1), 32'(g == 1));
        chk("stall0",     32'(st0),  32'(v0 && (g != 0)));
        chk("dm_we",      32'(dm_we), 32'(e_we));
        chk("dm_addr",    32'(dm_addr), e_addr);
        chk("dm_wdata",   dm_wdata, e_wdata);

        if (reset) begin
            m_wait = 0;
            m_rv0  = 1'b0;
            m_rv1  = 1'b0;
            m_rd0  = '0;
            m_rd1  = '0;
        end else begin
            m_rv0 = (g == 0) && !we0;
            m_rv1 = (g == 1) && !we1;
            if (m_rv0) m_rd0 = shadow[a0];
            if (m_rv1) m_rd1 = shadow[a1];
            if (g == 0 && we0) shadow[a0] = d0;
            if (g == 1 && we1) shadow[a1] = d1;
            if (g == 1)                          m_wait = 0;
            else if (v1 && m_wait < int'(MAXW))  m_wait = m_wait + 1;
        end
    end

    // Drive one cycle of inputs just after the rising edge; return once
    // combinational outputs have settled for that cycle.
    task automatic cyc(input logic r,
                       input logic iv0, input logic iwe0, input logic [AW-1:0] ia0,
                       input logic [DW-1:0] id0,
                       input logic iv1, input logic iwe1, input logic [AW-1:0] ia1,
                       input logic [DW-1:0] id1);
        @(posedge clk);
        #1;
        reset = r;
        v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
        v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1;
        v0 = 1'b1; we0 = 1'b0; a0 = '0; d0 = '0;
        v1 = 1'b1; we1 = 1'b0; a1 = '0; d1 = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]    <= init_word(i);
            shadow[i]  = init_word(i);
        end

        // Reset held two cycles with both ports requesting.
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b0, 10'h002, '0);
            chk("rst_ready0", 32'(rdy0), 32'd0);
            chk("rst_ready1", 32'(rdy1), 32'd0);
            chk("rst_dm_we",  32'(dm_we), 32'd0);
            chk("rst_stall0", 32'(st0), 32'd1);
        end
        chk("rst_rsp0_valid", 32'(rv0), 32'd0);
        chk("rst_rsp1_valid", 32'(rv1), 32'd0);

        // Port 0 write then read-back of the same word.
        cyc(1'b0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        chk("wr_dm_we",   32'(dm_we), 32'd1);
        chk("wr_dm_addr", 32'(dm_addr), 32'h005);
        chk("wr_ready0",  32'(rdy0), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        chk("rd_ready0",  32'(rdy0), 32'd1);
        chk("rd_dm_we",   32'(dm_we), 32'd0);
        idle();
        chk("rd_rsp0_valid", 32'(rv0), 32'd1);
        chk("rd_rsp0_rdata", rd0, 32'hDEADBEEF);

        // Continuous contention: P0,P0,P0,P0,P1 repeating.
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b0, AW'(k), '0, 1'b1, 1'b0, AW'(10'h100 + k), '0);
            chk("rr_ready1", 32'(rdy1), 32'((k % 5) == 4));
            chk("rr_stall0", 32'(st0),  32'((k % 5) == 4));
        end

        // Port 1 alone: immediate grant, read returns the stored word.
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 32'hCAFEF00D);
        chk("p1wr_ready1", 32'(rdy1), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0);
        chk("p1rd_ready1", 32'(rdy1), 32'd1);
        idle();
        chk("p1rd_rsp1_valid", 32'(rv1), 32'd1);
        chk("p1rd_rsp1_rdata", rd1, 32'hCAFEF00D);

        // Two refusals, port 1 drops for three cycles, then two more refusals.
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 10'h010, '0, 1'b1, 1'b0, 10'h020, '0);
            chk("hold_ref_ready1", 32'(rdy1), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 10'h011, '0, 1'b0, 1'b0, '0, '0);
            chk("hold_drop_ready0", 32'(rdy0), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 10'h012, '0, 1'b1, 1'b0, 10'h021, '0);
            chk("hold_resume_ready1", 32'(rdy1), 32'(k == 2));
        end

        // Read granted, then reset on the following cycle.
        cyc(1'b0, 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        chk("rr_rd_ready0", 32'(rdy0), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        chk("rr_rsp0_valid", 32'(rv0), 32'd1);
        chk("rr_rsp0_rdata", rd0, 32'hDEADBEEF);
        chk("rr_ready0_rst", 32'(rdy0), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        chk("rr_rsp0_valid_rst", 32'(rv0), 32'd0);
        chk("rr_rsp0_rdata_rst", rd0, 32'd0);

        // Randomized traffic on a narrow address window to force reuse.
        for (int k = 0; k < 3000; k++) begin
            logic          r, iv0, iwe0, iv1, iwe1;
            logic [AW-1:0] ia0, ia1;
            r    = ($urandom_range(63) == 0);
            iv0  = ($urandom_range(3) != 0);
            iv1  = ($urandom_range(3) != 0);
            iwe0 = $urandom_range(1) == 1;
            iwe1 = $urandom_range(1) == 1;
            ia0  = ($urandom_range(15) == 0) ? AW'($urandom) : AW'($urandom_range(15));
            ia1  = ($urandom_range(15) == 0) ? AW'($urandom) : AW'($urandom_range(15));
            cyc(r, iv0, iwe0, ia0, $urandom, iv1, iwe1, ia1, $urandom);
        end

        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
